// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and the 12-bit colour layout shared by
// the scan controller and the draw_* pixel generators.
package vga_timing_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
  localparam int HS_START_D = H_ACTIVE_D + H_FP_D;
  localparam int HS_END_D   = HS_START_D + H_SYNC_D - 1;
  localparam int VS_START_D = V_ACTIVE_D + V_FP_D;
  localparam int VS_END_D   = VS_START_D + V_SYNC_D - 1;

  localparam int HW = 11;
  localparam int VW = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

endpackage

// File: rtl/sig_delay.sv
// Generic clk-rate shift register; DEPTH=0 degenerates to a wire.
module sig_delay #(
  parameter int                WIDTH     = 1,
  parameter int                DEPTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] stage;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage <= {DEPTH{RESET_VAL}};
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end
      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster timing master: pixel divider, h/v scan counters, frame tick, and
// sync/blank decode delayed to line up with the registered pixel pipeline.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int CLK_DIV  = 4,
  parameter int PIX_LAT  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [11:0]   pixel,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          pix_en,
  output logic          frame_tick,
  output logic          hsync,
  output logic          vsync,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          last_h, last_v;
  logic          hs_raw, vs_raw, act_raw;
  logic          hs_d, vs_d, act_d;
  rgb_t          rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div <= '0;
    else        div <= (div == DIV_MAX) ? '0 : div + 1'b1;
  end

  assign pix_en = (div == DIV_MAX);
  assign last_h = (hcount == HW'(H_TOTAL - 1));
  assign last_v = (vcount == VW'(V_TOTAL - 1));

  // Line and frame wrap resolve on the same edge; (0,V_TOTAL) never appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (last_h) begin
        hcount <= '0;
        vcount <= last_v ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  assign frame_tick = pix_en & last_h & last_v;

  assign hs_raw  = !(hcount >= HW'(HS_START) && hcount <= HW'(HS_END));
  assign vs_raw  = !(vcount >= VW'(VS_START) && vcount <= VW'(VS_END));
  assign act_raw = (hcount < HW'(H_ACTIVE)) && (vcount < VW'(V_ACTIVE));

  // Match the drawing pipeline latency so sync/blank line up with pixel.
  sig_delay #(
    .WIDTH    (3),
    .DEPTH    (PIX_LAT),
    .RESET_VAL(3'b110)
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({hs_raw, vs_raw, act_raw}),
    .q    ({hs_d, vs_d, act_d})
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else begin
      hsync <= hs_d;
      vsync <= vs_d;
      rgb   <= act_d ? rgb_t'(pixel) : '0;
    end
  end

  assign vga_r = rgb.r;
  assign vga_g = rgb.g;
  assign vga_b = rgb.b;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl on a shrunken 24x11 raster, CLK_DIV=4,
// PIX_LAT=1: hsync at h 18..20, vsync at v 7..8, active 16x6, frame 1056 clk.
module tb_vga_scan_ctrl;

  localparam int HS_LOW_CLK = 3 * 4;
  localparam int VS_LOW_CLK = 2 * 24 * 4;
  localparam int FRAME_CLK  = 24 * 11 * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] pixel;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        pix_en, frame_tick, hsync, vsync;
  logic [3:0]  vga_r, vga_g, vga_b;

  vga_scan_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(4),   .PIX_LAT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel(pixel),
    .hcount(hcount), .vcount(vcount), .pix_en(pix_en), .frame_tick(frame_tick),
    .hsync(hsync), .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n; int hc; int vc; bit pe; bit ft; bit hs; bit vs; int rgb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc;
  int   hs_len, vs_len, hs_runs = 0, vs_runs = 0, ticks = 0, last_tick;

  // Edges since the most recent reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic exp_t mk(int n, int hc, int vc, bit pe, bit ft,
                              bit hs, bit vs, int rgb);
    exp_t e;
    e.n = n; e.hc = hc; e.vc = vc; e.pe = pe; e.ft = ft;
    e.hs = hs; e.vs = vs; e.rgb = rgb;
    return e;
  endfunction

  // Monitor: pops a vector when its cycle arrives, and measures pulse widths.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hs_len = 0; vs_len = 0; last_tick = -1;
    end else begin
      while (q.size() > 0 && q[0].n < cyc) begin
        e = q.pop_front();
        chk("vec_missed", cyc, e.n);
      end
      if (q.size() > 0 && q[0].n == cyc) begin
        e = q.pop_front();
        chk("hcount", int'(hcount), e.hc);
        chk("vcount", int'(vcount), e.vc);
        chk("pix_en", int'(pix_en), int'(e.pe));
        chk("frame_tick", int'(frame_tick), int'(e.ft));
        chk("hsync", int'(hsync), int'(e.hs));
        chk("vsync", int'(vsync), int'(e.vs));
        chk("rgb", int'({vga_r, vga_g, vga_b}), e.rgb);
      end
      if (!hsync) hs_len++;
      else if (hs_len > 0) begin
        chk("hsync_width", hs_len, HS_LOW_CLK); hs_runs++; hs_len = 0;
      end
      if (!vsync) vs_len++;
      else if (vs_len > 0) begin
        chk("vsync_width", vs_len, VS_LOW_CLK); vs_runs++; vs_len = 0;
      end
      if (frame_tick) begin
        ticks++;
        if (last_tick >= 0) chk("tick_gap", cyc - last_tick, FRAME_CLK);
        last_tick = cyc;
      end
    end
  end

  task automatic wait_cyc(input int target);
    int g = 0;
    while (cyc != target && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != target) chk("timeout", cyc, target);
  endtask

  task automatic push_start();
    q.push_back(mk(1, 0, 0, 0, 0, 1, 1, 'h000));
    q.push_back(mk(2, 0, 0, 0, 0, 1, 1, 'hA5C));
    q.push_back(mk(3, 0, 0, 1, 0, 1, 1, 'hA5C));
    q.push_back(mk(4, 1, 0, 0, 0, 1, 1, 'hA5C));
  endtask

  initial begin
    rst_n = 1'b0;
    pixel = 12'hFFF;
    repeat (3) @(negedge clk);
    chk("rst_hcount", int'(hcount), 0);
    chk("rst_vcount", int'(vcount), 0);
    chk("rst_pix_en", int'(pix_en), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);

    push_start();
    q.push_back(mk(65,   16, 0,  0, 0, 1, 1, 'hA5C));
    q.push_back(mk(66,   16, 0,  0, 0, 1, 1, 'h000));
    q.push_back(mk(73,   18, 0,  0, 0, 1, 1, 'h000));
    q.push_back(mk(74,   18, 0,  0, 0, 0, 1, 'h000));
    q.push_back(mk(85,   21, 0,  0, 0, 0, 1, 'h000));
    q.push_back(mk(86,   21, 0,  0, 0, 1, 1, 'h000));
    q.push_back(mk(95,   23, 0,  1, 0, 1, 1, 'h000));
    q.push_back(mk(96,   0,  1,  0, 0, 1, 1, 'h000));
    q.push_back(mk(98,   0,  1,  0, 0, 1, 1, 'hA5C));
    q.push_back(mk(482,  0,  5,  0, 0, 1, 1, 'hA5C));
    q.push_back(mk(575,  23, 5,  1, 0, 1, 1, 'h000));
    q.push_back(mk(576,  0,  6,  0, 0, 1, 1, 'h000));
    q.push_back(mk(578,  0,  6,  0, 0, 1, 1, 'h000));
    q.push_back(mk(673,  0,  7,  0, 0, 1, 1, 'h000));
    q.push_back(mk(674,  0,  7,  0, 0, 1, 0, 'h000));
    q.push_back(mk(746,  18, 7,  0, 0, 0, 0, 'h000));
    q.push_back(mk(865,  0,  9,  0, 0, 1, 0, 'h000));
    q.push_back(mk(866,  0,  9,  0, 0, 1, 1, 'h000));
    q.push_back(mk(1054, 23, 10, 0, 0, 1, 1, 'h000));
    q.push_back(mk(1055, 23, 10, 1, 1, 1, 1, 'h000));
    q.push_back(mk(1056, 0,  0,  0, 0, 1, 1, 'h000));
    q.push_back(mk(1058, 0,  0,  0, 0, 1, 1, 'hA5C));
    q.push_back(mk(3534, 19, 3,  0, 0, 0, 1, 'h000));

    pixel = 12'hA5C;
    rst_n = 1'b1;

    wait_cyc(3300);
    chk("frame_ticks", ticks, 3);
    chk("hsync_runs", hs_runs, 34);
    chk("vsync_runs", vs_runs, 3);

    // Reset lands mid-hsync, between clock edges.
    wait_cyc(3534);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_hsync", int'(hsync), 1);
    chk("mid_rst_hcount", int'(hcount), 0);
    chk("mid_rst_vcount", int'(vcount), 0);
    chk("mid_rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
    repeat (2) @(negedge clk);

    push_start();
    q.push_back(mk(74, 18, 0, 0, 0, 0, 1, 'h000));
    rst_n = 1'b1;
    wait_cyc(100);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
